td4x_core: RTL
==============

# td4x_core

Parametrised successor of the 4-bit TD4-style CPU core: two general registers (A, B), an output register, a carry flag and a program counter. Data width and program-address width are parameters. Single clock domain: a `tick` clock-enable replaces the divided clock. Adds a run/step/halt control state machine and a HLT opcode. Instruction memory is external and combinational, so it sits between the board top (switches, 7-seg, divider) and a ROM.

## Interface
Parameters:
- DW, 4, data width of A, B, OUT, immediate, in/out ports; DW >= 1
- AW, 4, PC / instruction address width; AW <= DW is required

Ports:
- clk  in  1  system clock
- RST  in  1  reset, synchronous, active-high
- tick  in  1  execute enable in RUN state, e.g. 1 Hz strobe from a divider
- run  in  1  level; 1 = free-run on tick, 0 = stop
- step  in  1  single-step request; rising edge detected internally
- instr_addr  out  AW  current PC
- instr_data  in  4+DW  instruction at `instr_addr`, valid in the same cycle; [DW+3:DW] = opcode, [DW-1:0] = imm
- in_port  in  DW  input port (switches)
- out_port  out  DW  output register
- out_strobe  out  1  one-cycle pulse when an OUT instruction executes
- halted  out  1  state == HALTED
- running  out  1  state == RUN
- dbg_a, dbg_b  out  DW  A and B register values
- dbg_c  out  1  carry flag

## Operation
- States: STOP, RUN, HALTED. Reset state is STOP.
- step_rise = step & ~step_q, where step_q is a register. step_q resets to 0.
- exec = (RUN & tick) | (STOP & step_rise). HALTED never executes.
- Transitions:
  - STOP→RUN when run=1.
  - RUN→STOP when run=0.
  - Any executing state→HALTED when exec and op=HLT. HLT takes priority over the run-based transition.
  - HALTED is left only by RST.
- STOP with run=1 and step_rise in the same cycle: the step executes, and the state is RUN next cycle.
- step is ignored in RUN; tick is ignored in STOP.
- ALU: {cout, sum} = src + imm, computed DW+1 wide. src is selected per opcode from A, B, in_port, or 0.
- Opcodes, encoded as op: destination ← sum, with the source in brackets:
  - 0000 ADD A,imm: A ← sum [A]
  - 0001 MOV A,B: A ← sum [B, imm forced 0]
  - 0010 IN A: A ← sum [in_port, imm forced 0]
  - 0011 MOV A,imm: A ← sum [0]
  - 0100 MOV B,A: B ← sum [A, imm forced 0]
  - 0101 ADD B,imm: B ← sum [B]
  - 0110 IN B: B ← sum [in_port, imm forced 0]
  - 0111 MOV B,imm: B ← sum [0]
  - 1001 OUT B: out_port ← sum [B, imm forced 0]
  - 1011 OUT imm: out_port ← sum [0]
  - 1110 JNC imm: PC ← imm[AW-1:0] if C=0, else PC+1
  - 1111 JMP imm: PC ← imm[AW-1:0]
  - 1101 HLT: no register change; PC is not incremented
  - 1000, 1010, 1100 (reserved): NOP; PC+1, C unchanged
- Carry: on every executed defined non-HLT opcode, C ← cout. This includes a not-taken JNC, which clears C.
- PC: PC+1 modulo 2^AW, wrapping from all-ones to 0. Jumps load the truncated imm.
- out_strobe = 1 for exactly one cycle after the edge on which OUT B or OUT imm executes. A repeated OUT value still pulses.

## Timing
- Reset values: A=B=out_port=0, PC=0, C=0, out_strobe=0, state=STOP, halted=0, running=0.
- One instruction per exec cycle. All architectural registers update on the clk edge where exec=1.
- instr_addr is registered. instr_data must settle combinationally within the same cycle; there is no fetch latency.
- running and halted reflect state from the cycle after the transition edge.
- RST mid-execution: synchronous RST overrides exec. All state returns to reset values on that edge regardless of tick, step or run.
- tick held high continuously in RUN executes one instruction per clk.

## Test plan
- DW=4, AW=4, run=1, tick=1 every cycle, program 0x33, 0x02, 0x40, 0x90, 0xD0. Required: A=5, B=5, out_port=5 with one out_strobe pulse, halted=1 with PC=4 held, and no change over 10 further ticks.
- Carry program 0x3F, 0x01, 0xE0, 0xE0, 0xF0. Required: after ADD, A=0 and C=1; first JNC not taken (PC=3) and C→0; second JNC taken to PC=0.
- run=0, step held high 5 cycles, then low, then high again. Required: exactly one instruction per rising edge (PC 0→1→2); tick pulses in STOP have no effect.
- DW=8, AW=8: MOV A,0xFF; ADD A,0x01 gives A=0x00, C=1. JMP 0xFF followed by NOP (0x8_00) wraps PC to 0x00.
- IN A with in_port=0xA (DW=4). Required: A=0xA, C=0. OUT imm 0x7 gives out_port=7 and a strobe.
- RST asserted mid-run with tick=1. Required: all outputs at reset values on the next cycle and state STOP; run held 1 re-enters RUN one cycle later.

Source files
------------

// File: rtl/td4x_core.sv
// TD4-style accumulator CPU core: A/B registers, carry flag, output register and PC,
// sequenced by a STOP/RUN/HALTED controller; instruction memory is external and combinational.
module td4x_core #(
    parameter int DW = 4,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          RST,
    input  logic          tick,
    input  logic          run,
    input  logic          step,
    output logic [AW-1:0] instr_addr,
    input  logic [DW+3:0] instr_data,
    input  logic [DW-1:0] in_port,
    output logic [DW-1:0] out_port,
    output logic          out_strobe,
    output logic          halted,
    output logic          running,
    output logic [DW-1:0] dbg_a,
    output logic [DW-1:0] dbg_b,
    output logic          dbg_c
);
    typedef enum logic [1:0] {
        ST_STOP   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    localparam logic [3:0] OP_ADD_A   = 4'b0000;
    localparam logic [3:0] OP_MOV_AB  = 4'b0001;
    localparam logic [3:0] OP_IN_A    = 4'b0010;
    localparam logic [3:0] OP_MOV_AI  = 4'b0011;
    localparam logic [3:0] OP_MOV_BA  = 4'b0100;
    localparam logic [3:0] OP_ADD_B   = 4'b0101;
    localparam logic [3:0] OP_IN_B    = 4'b0110;
    localparam logic [3:0] OP_MOV_BI  = 4'b0111;
    localparam logic [3:0] OP_OUT_B   = 4'b1001;
    localparam logic [3:0] OP_OUT_I   = 4'b1011;
    localparam logic [3:0] OP_HLT     = 4'b1101;
    localparam logic [3:0] OP_JNC     = 4'b1110;
    localparam logic [3:0] OP_JMP     = 4'b1111;

    state_e        state_q, state_d;
    logic [DW-1:0] a_q, a_d, b_q, b_d, out_q, out_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          c_q, c_d, strobe_q, strobe_d, step_q, step_d;

    logic [3:0]    op;
    logic [DW-1:0] imm, src, addend;
    logic [DW:0]   sum;
    logic          step_rise, exec;

    assign op        = instr_data[DW+3:DW];
    assign imm       = instr_data[DW-1:0];
    assign step_rise = step & ~step_q;
    assign exec      = ((state_q == ST_RUN) & tick) | ((state_q == ST_STOP) & step_rise);

    // Register moves are additions with a zeroed immediate, so they clear carry too.
    always_comb begin
        src    = '0;
        addend = imm;
        case (op)
            OP_ADD_A:          src = a_q;
            OP_ADD_B:          src = b_q;
            OP_MOV_AB:         begin src = b_q;     addend = '0; end
            OP_OUT_B:          begin src = b_q;     addend = '0; end
            OP_MOV_BA:         begin src = a_q;     addend = '0; end
            OP_IN_A, OP_IN_B:  begin src = in_port; addend = '0; end
            default:           ;
        endcase
        sum = {1'b0, src} + {1'b0, addend};
    end

    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        out_d    = out_q;
        pc_d     = pc_q;
        c_d      = c_q;
        strobe_d = 1'b0;
        step_d   = step;
        state_d  = state_q;

        case (state_q)
            ST_STOP:   if (run)  state_d = ST_RUN;
            ST_RUN:    if (!run) state_d = ST_STOP;
            ST_HALTED: ;
            default:   state_d = ST_STOP;
        endcase

        if (exec) begin
            pc_d = pc_q + AW'(1);
            c_d  = sum[DW];
            case (op)
                OP_ADD_A, OP_MOV_AB, OP_IN_A, OP_MOV_AI: a_d = sum[DW-1:0];
                OP_MOV_BA, OP_ADD_B, OP_IN_B, OP_MOV_BI: b_d = sum[DW-1:0];
                OP_OUT_B, OP_OUT_I: begin
                    out_d    = sum[DW-1:0];
                    strobe_d = 1'b1;
                end
                OP_JNC: if (!c_q) pc_d = imm[AW-1:0];
                OP_JMP: pc_d = imm[AW-1:0];
                OP_HLT: begin
                    pc_d    = pc_q;
                    c_d     = c_q;
                    state_d = ST_HALTED;
                end
                default: c_d = c_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q  <= ST_STOP;
            a_q      <= '0;
            b_q      <= '0;
            out_q    <= '0;
            pc_q     <= '0;
            c_q      <= 1'b0;
            strobe_q <= 1'b0;
            step_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            out_q    <= out_d;
            pc_q     <= pc_d;
            c_q      <= c_d;
            strobe_q <= strobe_d;
            step_q   <= step_d;
        end
    end

    assign instr_addr = pc_q;
    assign out_port   = out_q;
    assign out_strobe = strobe_q;
    assign halted     = (state_q == ST_HALTED);
    assign running    = (state_q == ST_RUN);
    assign dbg_a      = a_q;
    assign dbg_b      = b_q;
    assign dbg_c      = c_q;
endmodule
